router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx_if.sv | 30 +++
 rtl/router_pkt_tx.sv | 134 +++++++++++++
 tb/tb_router_pkt_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: command, payload and router-side signals of the packet transmitter.
// master = source/router side (drives start/payload/busy), slave = transmitter.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       cmd_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_done;
  logic       cmd_err;

  modport master (
    output start, dest_addr, payload_len,
    output pl_data, pl_valid, busy,
    input  cmd_ready, pl_ready,
    input  data_out, pkt_valid, tx_done, cmd_err
  );

  modport slave (
    input  start, dest_addr, payload_len,
    input  pl_data, pl_valid, busy,
    output cmd_ready, pl_ready,
    output data_out, pkt_valid, tx_done, cmd_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload, then sends header, payload and XOR parity to a router.
// Ports: clk, reset (sync, active-high), bus (router_pkt_tx_if.slave).
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input  logic clk,
  input  logic reset,
  router_pkt_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_DONE
  } state_t;

  localparam logic [6:0] MAX_L = 7'(MAX_LEN);

  state_t     state;
  logic [5:0] len_q;
  logic [1:0] addr_q;
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic [7:0] par_q;
  logic [7:0] dout_q;
  logic       pv_q;
  logic       done_q;
  logic       err_q;

  logic [7:0] buf_mem [MAX_LEN];

  logic       cmd_ok;
  logic       take;
  logic [5:0] wr_nxt;

  assign cmd_ok = (bus.dest_addr != 2'd3)
               && (bus.payload_len != 6'd0)
               && ({1'b0, bus.payload_len} <= MAX_L);
  assign take   = (state == S_LOAD) && bus.pl_valid;
  assign wr_nxt = wr_ptr + 6'd1;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.pl_ready  = (state == S_LOAD);
  assign bus.data_out  = dout_q;
  assign bus.pkt_valid = pv_q;
  assign bus.tx_done   = done_q;
  assign bus.cmd_err   = err_q;

  // Buffer is deliberately never cleared; stale bytes are never read
  // because rd_ptr is bounded by the latched length.
  always_ff @(posedge clk) begin
    if (take) buf_mem[wr_ptr] <= bus.pl_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      len_q  <= '0;
      addr_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      par_q  <= '0;
      dout_q <= '0;
      pv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (cmd_ok) begin
              len_q  <= bus.payload_len;
              addr_q <= bus.dest_addr;
              wr_ptr <= '0;
              // Header byte seeds the running parity.
              par_q  <= {bus.payload_len, bus.dest_addr};
              state  <= S_LOAD;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (take) begin
            wr_ptr <= wr_nxt;
            par_q  <= par_q ^ bus.pl_data;
            if (wr_nxt == len_q) begin
              dout_q <= {len_q, addr_q};
              pv_q   <= 1'b1;
              state  <= S_HEADER;
            end
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            dout_q <= buf_mem[0];
            rd_ptr <= 6'd1;
            state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          // rd_ptr is one past the byte currently on data_out.
          if (!bus.busy) begin
            if (rd_ptr == len_q) begin
              dout_q <= par_q;
              pv_q   <= 1'b0;
              state  <= S_PARITY;
            end else begin
              dout_q <= buf_mem[rd_ptr];
              rd_ptr <= rd_ptr + 6'd1;
            end
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            dout_q <= '0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: random packets checked against a byte-stream model of the packet.
// Model builds header/payload/parity lists and expects them in order on busy=0 edges.
module tb_router_pkt_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] pl_buf [64];

  always #5 clk = ~clk;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bad_cmd(input logic [1:0] addr, input logic [5:0] len);
    bus.start       = 1'b1;
    bus.dest_addr   = addr;
    bus.payload_len = len;
    tick();
    bus.start = 1'b0;
    chk("cmd_err_pulse", bus.cmd_err, 1);
    chk("cmd_ready_err", bus.cmd_ready, 1);
    chk("pkt_valid_err", bus.pkt_valid, 0);
    chk("pl_ready_err", bus.pl_ready, 0);
    tick();
    chk("cmd_err_clear", bus.cmd_err, 0);
    chk("cmd_ready_after", bus.cmd_ready, 1);
  endtask

  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input int vmode, input int busy_pct,
                          input int hdr_busy, input int abort_at);
    logic [7:0] exp_q [$];
    logic       epv_q [$];
    logic [7:0] par;
    logic       pv;
    logic       tgl;
    int i, idx, guard, hb;
    par = {len, addr};
    exp_q.push_back(par);
    epv_q.push_back(1'b1);
    for (int k = 0; k < int'(len); k++) begin
      exp_q.push_back(pl_buf[k]);
      epv_q.push_back(1'b1);
      par ^= pl_buf[k];
    end
    exp_q.push_back(par);
    epv_q.push_back(1'b0);

    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.start       = 1'b1;
    bus.dest_addr   = addr;
    bus.payload_len = len;
    tick();
    bus.start = 1'b0;
    chk("pl_ready_load", bus.pl_ready, 1);
    chk("cmd_ready_load", bus.cmd_ready, 0);

    i = 0; guard = 0; tgl = 1'b0;
    while (i < int'(len) && guard < 4000) begin
      case (vmode)
        0:       pv = 1'($urandom_range(0, 1));
        1:       begin pv = tgl; tgl = ~tgl; end
        default: pv = 1'b1;
      endcase
      bus.pl_valid    = pv;
      bus.pl_data     = pv ? pl_buf[i] : 8'($urandom);
      bus.start       = 1'($urandom_range(0, 1));
      bus.dest_addr   = 2'($urandom);
      bus.payload_len = 6'($urandom);
      bus.busy        = 1'($urandom_range(0, 1));
      tick();
      if (pv) i++;
      guard++;
    end
    chk("load_count", i, len);

    idx = 0; guard = 0; hb = 0;
    while (idx < int'(len) + 2 && guard < 4000) begin
      chk("data_out", bus.data_out, exp_q[idx]);
      chk("pkt_valid", bus.pkt_valid, epv_q[idx]);
      chk("tx_done_low", bus.tx_done, 0);
      chk("pl_ready_tx", bus.pl_ready, 0);
      if (idx == abort_at) begin
        reset    = 1'b1;
        bus.busy = 1'b0;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.pl_valid = 1'b0;
        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_tx_done", bus.tx_done, 0);
        return;
      end
      if (idx == 0 && hb < hdr_busy) begin
        bus.busy = 1'b1;
        hb++;
      end else begin
        bus.busy = ($urandom_range(0, 99) < busy_pct);
      end
      bus.start       = 1'($urandom_range(0, 1));
      bus.dest_addr   = 2'($urandom);
      bus.payload_len = 6'($urandom);
      bus.pl_valid    = 1'($urandom_range(0, 1));
      bus.pl_data     = 8'($urandom);
      tick();
      if (!bus.busy) idx++;
      guard++;
    end
    bus.start    = 1'b0;
    bus.pl_valid = 1'b0;
    bus.busy     = 1'($urandom_range(0, 1));
    chk("xfer_count", idx, int'(len) + 2);
    chk("tx_done_hi", bus.tx_done, 1);
    chk("done_data", bus.data_out, 0);
    chk("done_pv", bus.pkt_valid, 0);
    chk("done_cmd_rdy", bus.cmd_ready, 0);
    tick();
    chk("tx_done_lo", bus.tx_done, 0);
    chk("idle_cmd_rdy", bus.cmd_ready, 1);
  endtask

  task automatic fill_rand(input int len);
    for (int k = 0; k < len; k++) pl_buf[k] = 8'($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rl;
    logic [1:0] ra;
    bus.start       = 1'b0;
    bus.dest_addr   = '0;
    bus.payload_len = '0;
    bus.pl_data     = '0;
    bus.pl_valid    = 1'b0;
    bus.busy        = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_pl_ready", bus.pl_ready, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_pkt_valid", bus.pkt_valid, 0);
    chk("rst_tx_done", bus.tx_done, 0);
    chk("rst_cmd_err", bus.cmd_err, 0);

    pl_buf[0] = 8'hA5;
    pl_buf[1] = 8'h3C;
    send_pkt(2'd1, 6'd2, 2, 0, 0, -1);
    send_pkt(2'd1, 6'd2, 2, 0, 3, -1);

    bad_cmd(2'd3, 6'd5);
    bad_cmd(2'd1, 6'd0);
    bad_cmd(2'd3, 6'd0);

    fill_rand(63);
    send_pkt(2'd2, 6'd63, 1, 0, 0, -1);

    fill_rand(8);
    send_pkt(2'd0, 6'd8, 2, 0, 0, 2);
    fill_rand(5);
    send_pkt(2'd1, 6'd5, 0, 20, 0, -1);

    fill_rand(6);
    send_pkt(2'd0, 6'd6, 2, 0, 0, -1);
    fill_rand(4);
    send_pkt(2'd2, 6'd4, 2, 0, 0, -1);

    fill_rand(1);
    send_pkt(2'd1, 6'd1, 0, 50, 0, -1);

    for (int n = 0; n < 25; n++) begin
      rl = 6'($urandom_range(1, 63));
      ra = 2'($urandom_range(0, 2));
      fill_rand(int'(rl));
      send_pkt(ra, rl, $urandom_range(0, 2), $urandom_range(0, 60),
               $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(rl) + 1)
                                           : -1);
      if ($urandom_range(0, 3) == 0)
        bad_cmd(2'd3, 6'($urandom_range(0, 63)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
